// File: rtl/width_16to8.sv
// 16-to-8 width converter: buffers input words in a small FIFO and emits each as two bytes.
// Define WIDTH_16TO8_LSB_FIRST_EN to emit the low byte of each word first (default: high byte first).
module width_16to8 #(
    parameter int BUF_DEPTH = 2,
    parameter int PTR_W     = $clog2(BUF_DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [15:0] data_in,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [7:0]  data_out,
    output logic        byte_hi,
    output logic        busy
);

    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;

    logic [15:0]      mem_q [BUF_DEPTH];
    logic [15:0]      mem_d [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0] state_q, state_d;
    logic [7:0] data_out_q, data_out_d;
    logic [7:0] lo_reg_q, lo_reg_d;
    logic       valid_out_q, valid_out_d;
    logic       byte_hi_q, byte_hi_d;

    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        transfer;
    logic [15:0] head_word;
    logic [7:0]  first_byte;
    logic [7:0]  second_byte;

    // ready_in comes only from the registered count, so a full FIFO refuses even on a same-cycle pop.
    assign ready_in   = (count_q != FULL_CNT);
    assign push       = valid_in && ready_in;
    assign fifo_empty = (count_q == '0);
    assign transfer   = valid_out_q && ready_out;
    assign head_word  = mem_q[rd_ptr_q];

`ifdef WIDTH_16TO8_LSB_FIRST_EN
    assign first_byte  = head_word[7:0];
    assign second_byte = head_word[15:8];
`else
    assign first_byte  = head_word[15:8];
    assign second_byte = head_word[7:0];
`endif

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign byte_hi   = byte_hi_q;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        data_out_d  = data_out_q;
        lo_reg_d    = lo_reg_q;
        valid_out_d = valid_out_q;
        byte_hi_d   = byte_hi_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_out_d = 1'b0;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    data_out_d  = first_byte;
                    lo_reg_d    = second_byte;
                    valid_out_d = 1'b1;
                    byte_hi_d   = 1'b1;
                    state_d     = ST_HI;
                end
            end
            ST_HI: begin
                if (transfer) begin
                    data_out_d = lo_reg_q;
                    byte_hi_d  = 1'b0;
                    state_d    = ST_LO;
                end
            end
            ST_LO: begin
                // Chain straight into the next word when one is waiting, avoiding a bubble.
                if (transfer) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        data_out_d = first_byte;
                        lo_reg_d   = second_byte;
                        byte_hi_d  = 1'b1;
                        state_d    = ST_HI;
                    end else begin
                        valid_out_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                valid_out_d = 1'b0;
                byte_hi_d   = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            data_out_q  <= 8'h00;
            lo_reg_q    <= 8'h00;
            valid_out_q <= 1'b0;
            byte_hi_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            data_out_q  <= data_out_d;
            lo_reg_q    <= lo_reg_d;
            valid_out_q <= valid_out_d;
            byte_hi_q   <= byte_hi_d;
        end
    end

endmodule

// File: tb/tb_width_16to8.sv
// Scoreboard bench for width_16to8: directed words queue expected bytes, a monitor checks each transfer.
module tb_width_16to8;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] data_in;
    logic        valid_out;
    logic        ready_out;
    logic [7:0]  data_out;
    logic        byte_hi;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb_q[$];

    logic       stall_prev = 1'b0;
    logic [7:0] held_data  = 8'h00;
    logic       held_hi    = 1'b0;

    width_16to8 #(.BUF_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .byte_hi   (byte_hi),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Offer one word for up to max_cycles edges; queue its expected bytes only if it was taken.
    task automatic applyStimulus(input logic [15:0] word, input int max_cycles, output bit accepted);
        accepted = 1'b0;
        valid_in = 1'b1;
        data_in  = word;
        for (int i = 0; i < max_cycles && !accepted; i++) begin
            if (ready_in) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        data_in  = 16'hDEAD;
        if (accepted) begin
`ifdef WIDTH_16TO8_LSB_FIRST_EN
            sb_q.push_back({1'b1, word[7:0]});
            sb_q.push_back({1'b0, word[15:8]});
`else
            sb_q.push_back({1'b1, word[15:8]});
            sb_q.push_back({1'b0, word[7:0]});
`endif
        end
    endtask

    task automatic pushWord(input string name, input logic [15:0] word);
        bit acc;
        applyStimulus(word, 10, acc);
        checkOutput(name, 32'(acc), 32'd1);
    endtask

    task automatic doReset();
        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic waitDrain(input string name, input int max_cycles);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_pending"}, 32'(sb_q.size()), 32'd0);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_valid"}, 32'(valid_out), 32'd0);
    endtask

    task automatic waitValid(input string name, input int max_cycles);
        int n = 0;
        while (!valid_out && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 32'(valid_out), 32'd1);
    endtask

    // Monitor: sampled mid-cycle; a transfer happens at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_valid", 32'(valid_out), 32'd1);
                if (valid_out) begin
                    checkOutput("hold_data", 32'(data_out), 32'(held_data));
                    checkOutput("hold_byte_hi", 32'(byte_hi), 32'(held_hi));
                end
            end
            if (valid_out && ready_out) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no output at %0t", data_out, $time);
                end else begin
                    logic [8:0] exp_e;
                    exp_e = sb_q.pop_front();
                    checkOutput("out_byte", 32'(data_out), 32'(exp_e[7:0]));
                    checkOutput("out_byte_hi", 32'(byte_hi), 32'(exp_e[8]));
                end
            end
            stall_prev = valid_out && !ready_out;
            held_data  = data_out;
            held_hi    = byte_hi;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        data_in   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        doReset();

        $display("[TB] reset state");
        checkOutput("rst_valid_out", 32'(valid_out), 32'd0);
        checkOutput("rst_data_out", 32'(data_out), 32'h00);
        checkOutput("rst_byte_hi", 32'(byte_hi), 32'd0);
        checkOutput("rst_ready_in", 32'(ready_in), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        $display("[TB] single word");
        ready_out = 1'b1;
        pushWord("single_accept", 16'hA55A);
        checkOutput("no_bypass", 32'(valid_out), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("latency_valid", 32'(valid_out), 32'd1);
        checkOutput("latency_byte_hi", 32'(byte_hi), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("single_second_valid", 32'(valid_out), 32'd1);
        checkOutput("single_second_byte_hi", 32'(byte_hi), 32'd0);
        waitDrain("single", 10);

        $display("[TB] back-to-back");
        fork
            begin
                pushWord("b2b_accept0", 16'h1234);
                pushWord("b2b_accept1", 16'h5678);
                pushWord("b2b_accept2", 16'h9ABC);
            end
            begin
                waitValid("b2b_valid_rise", 20);
                for (int i = 0; i < 6; i++) begin
                    checkOutput("b2b_no_bubble", 32'(valid_out), 32'd1);
                    if (i < 5) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        join
        waitDrain("b2b", 20);

        $display("[TB] backpressure");
        ready_out = 1'b0;
        pushWord("bp_accept", 16'hBEEF);
        waitValid("bp_valid_rise", 10);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("bp_hold_data", 32'(data_out), 32'(first_of(16'hBEEF)));
        checkOutput("bp_hold_byte_hi", 32'(byte_hi), 32'd1);
        ready_out = 1'b1;
        waitDrain("bp", 20);

        $display("[TB] full buffer");
        ready_out = 1'b0;
        pushWord("full_accept0", 16'h0102);
        pushWord("full_accept1", 16'h0304);
        pushWord("full_accept2", 16'h0506);
        checkOutput("full_ready_in", 32'(ready_in), 32'd0);
        checkOutput("full_busy", 32'(busy), 32'd1);
        applyStimulus(16'h0708, 4, acc);
        checkOutput("full_reject", 32'(acc), 32'd0);
        ready_out = 1'b1;
        waitDrain("full", 40);

        $display("[TB] reset mid-word");
        ready_out = 1'b0;
        pushWord("rmw_accept0", 16'h1111);
        pushWord("rmw_accept1", 16'h2222);
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        checkOutput("rmw_in_lo", 32'(byte_hi), 32'd0);
        checkOutput("rmw_buffered", 32'(ready_in), 32'd1);
        doReset();
        checkOutput("rmw_valid_out", 32'(valid_out), 32'd0);
        checkOutput("rmw_busy", 32'(busy), 32'd0);
        checkOutput("rmw_ready_in", 32'(ready_in), 32'd1);
        ready_out = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rmw_quiet_valid", 32'(valid_out), 32'd0);
        checkOutput("rmw_quiet_busy", 32'(busy), 32'd0);

        $display("[TB] word after reset");
        pushWord("post_accept", 16'hC3D4);
        waitDrain("post", 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [7:0] first_of(input logic [15:0] word);
`ifdef WIDTH_16TO8_LSB_FIRST_EN
        return word[7:0];
`else
        return word[15:8];
`endif
    endfunction

endmodule
